rle_decoder: RTL

//   Run-length decoder; the downstream consumer of the runlength encoder output.

---
 rtl/rle_pkg.sv | 14 +
 rtl/rle_decoder_if.sv | 24 ++
 rtl/rle_decoder.sv | 92 +++++++++
 3 files changed

// File: rtl/rle_pkg.sv
// Shared run-length codec definitions: field widths, decoder FSM states and
// the width of the debug output counter. Used by encoder, pair stage, decoder.
package rle_pkg;

    localparam int CW_DEF = 8;
    localparam int DW_DEF = 8;
    localparam int TOT_W  = 16;

    typedef enum logic {
        IDLE   = 1'b0,
        EXPAND = 1'b1
    } rle_dec_state_t;

endpackage

// File: rtl/rle_decoder_if.sv
// Pair-in / byte-out stream bundle for the run-length decoder.
// slave: decoder side (takes pairs, drives bytes); master: upstream/sink side.
interface rle_decoder_if #(
    parameter int CW = 8,
    parameter int DW = 8
);
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_count;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;

    modport slave (
        input  in_valid, in_count, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_count, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/rle_decoder.sv
// Run-length decoder: expands each (count, byte) pair into count copies of byte.
// Ports: clk, rst (sync, active-high), bus (pair in / byte out stream),
//        zero_err (pulse on count-0 pair), busy, state, total_out (debug).
module rle_decoder
    import rle_pkg::*;
#(
    parameter int CW = CW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    rle_decoder_if.slave     bus,
    output logic             zero_err,
    output logic             busy,
    output logic             state,
    output logic [TOT_W-1:0] total_out
);

    rle_dec_state_t   r_state;
    logic [CW-1:0]    r_rem;
    logic [DW-1:0]    r_data;
    logic             r_out_valid;
    logic             r_zero_err;
    logic [TOT_W-1:0] r_total;

    logic w_last;
    logic w_expand;
    logic w_pair_ok;

    assign w_last    = (r_rem == CW'(1));
    assign w_expand  = (r_state == EXPAND);
    assign w_pair_ok = (bus.in_count != '0);

    // Combinational from out_ready so a new run can start on the edge
    // that retires the last byte of the current one.
    assign bus.in_ready  = !w_expand | (bus.out_ready & w_last);
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_data;

    assign zero_err  = r_zero_err;
    assign busy      = w_expand;
    assign state     = w_expand;
    assign total_out = r_total;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_rem       <= '0;
            r_data      <= '0;
            r_out_valid <= 1'b0;
            r_zero_err  <= 1'b0;
            r_total     <= '0;
        end else begin
            r_zero_err <= 1'b0;
            if (r_out_valid && bus.out_ready)
                r_total <= r_total + TOT_W'(1);
            unique case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        if (w_pair_ok) begin
                            r_data      <= bus.in_data;
                            r_rem       <= bus.in_count;
                            r_out_valid <= 1'b1;
                            r_state     <= EXPAND;
                        end else begin
                            r_zero_err <= 1'b1;
                        end
                    end
                end
                EXPAND: begin
                    if (bus.out_ready) begin
                        if (!w_last) begin
                            r_rem <= r_rem - CW'(1);
                        end else if (bus.in_valid && w_pair_ok) begin
                            r_data <= bus.in_data;
                            r_rem  <= bus.in_count;
                        end else begin
                            // Pair (if any) is bad; drop it and fall idle.
                            r_zero_err  <= bus.in_valid;
                            r_rem       <= '0;
                            r_data      <= '0;
                            r_out_valid <= 1'b0;
                            r_state     <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
